// File: rtl/tri_reader_pkg.sv
// Shared types and size helpers for the pipelined block reader.
package tri_reader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_e;

  // Widest supported Avalon bus is 64 bits; callers slice down to AVM_DW/8.
  localparam logic [7:0] AVM_BE_ALL = 8'hFF;

  function automatic int calc_beats(input int block_words, input int avm_dw);
    return (32 * block_words) / avm_dw;
  endfunction

  function automatic int calc_block_bytes(input int block_words);
    return 4 * block_words;
  endfunction

endpackage

// File: rtl/tri_block_reader_sync_fifo.sv
// Small synchronous FIFO with registered storage; head is read combinationally
// from the storage array so a push into an empty FIFO is visible next cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                      (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign o_count    = r_wptr - r_rptr;
  assign o_pop_data = r_mem[r_rptr[PTR_W-1:0]];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is cleared so the head reads as zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/tri_block_reader.sv
// Pipelined Avalon-MM block reader: up to MAX_OUTSTANDING blocks in flight, in-order output.
// Optional TRI_BLOCK_READER_TAG_EN adds a 'tag' output carrying each block's index.
module tri_block_reader
  import tri_reader_pkg::*;
#(
  parameter int BLOCK_WORDS     = 1,
  parameter int AVM_DW          = 16,
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        baseaddr,
  input  logic [31:0]              index,
  input  logic                     read,
  output logic                     ready,
  output logic [32*BLOCK_WORDS-1:0] data,
  output logic                     ovalid,
  input  logic                     iready,
  output logic                     avm_m0_read,
  output logic                     avm_m0_write,
  output logic [AVM_DW-1:0]        avm_m0_writedata,
  output logic [ADDR_W-1:0]        avm_m0_address,
  output logic [AVM_DW/8-1:0]      avm_m0_byteenable,
  input  logic [AVM_DW-1:0]        avm_m0_readdata,
  input  logic                     avm_m0_readdatavalid,
  input  logic                     avm_m0_waitrequest
`ifdef TRI_BLOCK_READER_TAG_EN
  ,
  output logic [31:0]              tag
`endif
);

  localparam int BLOCK_W     = 32 * BLOCK_WORDS;
  localparam int BEATS       = calc_beats(BLOCK_WORDS, AVM_DW);
  localparam int BLOCK_BYTES = calc_block_bytes(BLOCK_WORDS);
  localparam int BEAT_BYTES  = AVM_DW / 8;
  localparam int BEAT_CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CREDIT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OUTB_W      = $clog2(MAX_OUTSTANDING * BEATS + 1);
  localparam logic [BEAT_CW-1:0]  LAST_BEAT  = BEAT_CW'(BEATS - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_OUTSTANDING);

  issue_state_e        r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [BEAT_CW-1:0]  r_issue_beat, w_issue_beat_next;
  logic [BEAT_CW-1:0]  r_rx_beat;
  logic [CREDIT_W-1:0] r_credit;
  logic [OUTB_W-1:0]   r_out_beats;
  logic                r_run;

  logic                w_accept;
  logic                w_pop;
  logic                w_issue_fire;
  logic                w_rdv_ok;
  logic                w_rx_last;
  logic [ADDR_W-1:0]   w_block_addr;
  logic [BLOCK_W-1:0]  w_asm_next;
  logic                w_dfifo_full;
  logic                w_dfifo_empty;
  logic [CREDIT_W-1:0] w_dfifo_count;

  assign avm_m0_write      = 1'b0;
  assign avm_m0_writedata  = '0;
  assign avm_m0_byteenable = AVM_BE_ALL[AVM_DW/8-1:0];
  assign avm_m0_read       = (r_state == ISSUE);
  assign avm_m0_address    = r_addr;

  // r_run keeps ready low until the first clock after reset release.
  assign ready        = r_run && (r_state == IDLE) && (r_credit < CREDIT_MAX);
  assign w_accept     = read && ready;
  assign w_pop        = iready && !w_dfifo_empty;
  assign w_issue_fire = (r_state == ISSUE) && !avm_m0_waitrequest;
  assign w_block_addr = baseaddr + ADDR_W'(index) * ADDR_W'(BLOCK_BYTES);

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_issue_beat_next = r_issue_beat;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next      = ISSUE;
          w_addr_next       = w_block_addr;
          w_issue_beat_next = '0;
        end
      end
      ISSUE: begin
        if (!avm_m0_waitrequest) begin
          w_addr_next = r_addr + ADDR_W'(BEAT_BYTES);
          if (r_issue_beat == LAST_BEAT) begin
            w_state_next      = IDLE;
            w_issue_beat_next = '0;
          end else begin
            w_issue_beat_next = r_issue_beat + BEAT_CW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_issue_beat <= '0;
      r_run        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_issue_beat <= w_issue_beat_next;
      r_run        <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit + CREDIT_W'(1);
        2'b01:   r_credit <= r_credit - CREDIT_W'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Beats issued but not yet returned; stray readdatavalid with none pending is dropped.
  assign w_rdv_ok = avm_m0_readdatavalid && ((r_out_beats != '0) || w_issue_fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_beats <= '0;
    end else begin
      case ({w_issue_fire, w_rdv_ok})
        2'b10:   r_out_beats <= r_out_beats + OUTB_W'(1);
        2'b01:   r_out_beats <= r_out_beats - OUTB_W'(1);
        default: r_out_beats <= r_out_beats;
      endcase
    end
  end

  assign w_rx_last = w_rdv_ok && (r_rx_beat == LAST_BEAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_beat <= '0;
    end else if (w_rdv_ok) begin
      r_rx_beat <= (r_rx_beat == LAST_BEAT) ? '0 : r_rx_beat + BEAT_CW'(1);
    end
  end

  generate
    if (BEATS == 1) begin : g_single
      assign w_asm_next = avm_m0_readdata;
    end else begin : g_shift
      // Only the older beats are stored; the newest beat is appended on the fly.
      logic [BLOCK_W-AVM_DW-1:0] r_asm;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_asm <= '0;
        end else if (w_rdv_ok) begin
          r_asm <= w_asm_next[BLOCK_W-AVM_DW-1:0];
        end
      end
      assign w_asm_next = {r_asm, avm_m0_readdata};
    end
  endgenerate

  sync_fifo #(
    .WIDTH (BLOCK_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_data_fifo (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_push      (w_rx_last && !w_dfifo_full),
    .i_push_data (w_asm_next),
    .i_pop       (w_pop),
    .o_pop_data  (data),
    .o_full      (w_dfifo_full),
    .o_empty     (w_dfifo_empty),
    .o_count     (w_dfifo_count)
  );

  assign ovalid = (w_dfifo_count != '0);

`ifdef TRI_BLOCK_READER_TAG_EN
  logic                w_tfifo_full_unused;
  logic                w_tfifo_empty_unused;
  logic [CREDIT_W-1:0] w_tfifo_count_unused;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_push      (w_accept),
    .i_push_data (index),
    .i_pop       (w_pop),
    .o_pop_data  (tag),
    .o_full      (w_tfifo_full_unused),
    .o_empty     (w_tfifo_empty_unused),
    .o_count     (w_tfifo_count_unused)
  );
`endif

endmodule

// File: tb/tb_tri_block_reader.sv
// Scoreboard bench for tri_block_reader: narrow (16-bit, 1 word) and wide (32-bit, 4 word) instances.
module tb_tri_block_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // narrow instance
  logic [31:0] a_base, a_index, a_data, a_addr, a_tag;
  logic        a_read, a_ready, a_ovalid, a_iready, a_avm_read, a_write;
  logic [15:0] a_wdata, a_rdata;
  logic [1:0]  a_be;
  logic        a_rdv, a_wait;

  // wide instance
  logic [31:0]  b_base, b_index, b_addr, b_wdata, b_rdata, b_tag;
  logic [127:0] b_data;
  logic         b_read, b_ready, b_ovalid, b_iready, b_avm_read, b_write, b_rdv, b_wait;
  logic [3:0]   b_be;

  tri_block_reader #(.BLOCK_WORDS(1), .AVM_DW(16), .ADDR_W(32), .MAX_OUTSTANDING(4)) dut_a (
`ifdef TRI_BLOCK_READER_TAG_EN
    .tag(a_tag),
`endif
    .clk(clk), .reset(rst_n), .baseaddr(a_base), .index(a_index), .read(a_read),
    .ready(a_ready), .data(a_data), .ovalid(a_ovalid), .iready(a_iready),
    .avm_m0_read(a_avm_read), .avm_m0_write(a_write), .avm_m0_writedata(a_wdata),
    .avm_m0_address(a_addr), .avm_m0_byteenable(a_be), .avm_m0_readdata(a_rdata),
    .avm_m0_readdatavalid(a_rdv), .avm_m0_waitrequest(a_wait));

  tri_block_reader #(.BLOCK_WORDS(4), .AVM_DW(32), .ADDR_W(32), .MAX_OUTSTANDING(4)) dut_b (
`ifdef TRI_BLOCK_READER_TAG_EN
    .tag(b_tag),
`endif
    .clk(clk), .reset(rst_n), .baseaddr(b_base), .index(b_index), .read(b_read),
    .ready(b_ready), .data(b_data), .ovalid(b_ovalid), .iready(b_iready),
    .avm_m0_read(b_avm_read), .avm_m0_write(b_write), .avm_m0_writedata(b_wdata),
    .avm_m0_address(b_addr), .avm_m0_byteenable(b_be), .avm_m0_readdata(b_rdata),
    .avm_m0_readdatavalid(b_rdv), .avm_m0_waitrequest(b_wait));

  typedef struct {int due; logic [31:0] data;} pend_t;

  pend_t        a_pend[$];
  logic [31:0]  a_exp_addr_q[$];
  logic [15:0]  a_beat_q[$];
  logic [31:0]  a_exp_out_q[$];
  logic [31:0]  a_exp_tag_q[$];
  int           a_lat = 1, a_cyc = 0, a_rdv_cnt = 0, a_wait_left = 0;
  logic [31:0]  a_wait_addr = 0, a_held_addr = 0;
  logic         a_wait_prev = 0;

  pend_t        b_pend[$];
  logic [31:0]  b_exp_addr_q[$];
  logic [31:0]  b_beat_q[$];
  logic [127:0] b_exp_out_q[$];
  logic [31:0]  b_exp_tag_q[$];
  int           b_cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [127:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, expected nothing", nm, act);
  endtask

  // Queue one narrow-bus block: two beat addresses, two beats, optional expected output.
  task automatic exp_a(input logic [31:0] addr0, input logic [15:0] b0, input logic [15:0] b1,
                       input logic [31:0] tg, input bit want_out);
    a_exp_addr_q.push_back(addr0);
    a_exp_addr_q.push_back(addr0 + 32'd2);
    a_beat_q.push_back(b0);
    a_beat_q.push_back(b1);
    if (want_out) begin
      a_exp_out_q.push_back({b0, b1});
      a_exp_tag_q.push_back(tg);
    end
  endtask

  task automatic do_req(input logic [31:0] base, input logic [31:0] idx, output int acc_cyc);
    int n = 0;
    a_read = 1'b1; a_base = base; a_index = idx;
    while (!a_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!a_ready) chk("a_req_timeout", 0, 1);
    @(posedge clk); #1;
    acc_cyc = cyc_cnt;
    a_read = 1'b0;
  endtask

  task automatic do_req_b(input logic [31:0] base, input logic [31:0] idx);
    int n = 0;
    b_read = 1'b1; b_base = base; b_index = idx;
    while (!b_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!b_ready) chk("b_req_timeout", 0, 1);
    @(posedge clk); #1;
    b_read = 1'b0;
  endtask

  task automatic drain_a(input string nm);
    int n = 0;
    while ((a_exp_out_q.size() != 0 || a_exp_addr_q.size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_drained"}, (a_exp_out_q.size() == 0 && a_exp_addr_q.size() == 0), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // narrow memory model: waitrequest injection, address check, fixed-latency responses
  initial begin
    a_wait = 1'b0; a_rdv = 1'b0; a_rdata = '0;
    forever begin
      @(negedge clk);
      a_cyc++;
      if (a_wait_prev) begin
        chk("a_wait_hold_read", a_avm_read, 1);
        chk("a_wait_hold_addr", a_addr, a_held_addr);
      end
      a_rdv = 1'b0; a_rdata = '0;
      if (a_pend.size() > 0 && a_pend[0].due <= a_cyc) begin
        a_rdv = 1'b1;
        a_rdata = a_pend[0].data[15:0];
        void'(a_pend.pop_front());
        a_rdv_cnt++;
      end
      a_wait = 1'b0;
      if (a_avm_read && a_wait_left > 0 && a_addr == a_wait_addr) begin
        a_wait = 1'b1;
        a_wait_left--;
        a_held_addr = a_addr;
      end
      a_wait_prev = a_wait;
      if (a_avm_read && !a_wait) begin
        if (a_exp_addr_q.size() == 0) unexpected("a_unexpected_read", a_addr);
        else chk("a_addr", a_addr, a_exp_addr_q.pop_front());
        if (a_beat_q.size() > 0) a_pend.push_back('{a_cyc + a_lat, {16'h0, a_beat_q.pop_front()}});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (a_ovalid && a_iready) begin
        if (a_exp_out_q.size() == 0) unexpected("a_unexpected_out", a_data);
        else begin
          chk("a_data", a_data, a_exp_out_q.pop_front());
`ifdef TRI_BLOCK_READER_TAG_EN
          chk("a_tag", a_tag, a_exp_tag_q.pop_front());
`else
          void'(a_exp_tag_q.pop_front());
`endif
        end
      end
    end
  end

  initial begin
    b_wait = 1'b0; b_rdv = 1'b0; b_rdata = '0;
    forever begin
      @(negedge clk);
      b_cyc++;
      b_rdv = 1'b0; b_rdata = '0;
      if (b_pend.size() > 0 && b_pend[0].due <= b_cyc) begin
        b_rdv = 1'b1;
        b_rdata = b_pend[0].data;
        void'(b_pend.pop_front());
      end
      if (b_avm_read) begin
        if (b_exp_addr_q.size() == 0) unexpected("b_unexpected_read", b_addr);
        else chk("b_addr", b_addr, b_exp_addr_q.pop_front());
        if (b_beat_q.size() > 0) b_pend.push_back('{b_cyc + 2, b_beat_q.pop_front()});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (b_ovalid && b_iready) begin
        if (b_exp_out_q.size() == 0) unexpected("b_unexpected_out", b_data);
        else begin
          chk("b_data", b_data, b_exp_out_q.pop_front());
`ifdef TRI_BLOCK_READER_TAG_EN
          chk("b_tag", b_tag, b_exp_tag_q.pop_front());
`else
          void'(b_exp_tag_q.pop_front());
`endif
        end
      end
    end
  end

  initial begin
    int acc0, acc1, acc2, cnt0, n;
    rst_n = 1'b0;
    a_read = 1'b0; a_base = '0; a_index = '0; a_iready = 1'b0;
    b_read = 1'b0; b_base = '0; b_index = '0; b_iready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_ovalid", a_ovalid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_a_read", a_avm_read, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_a_write", a_write, 0);
    chk("rst_a_be", a_be, 2'b11);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_b_be", b_be, 4'hF);
`ifdef TRI_BLOCK_READER_TAG_EN
    chk("rst_a_tag", a_tag, 0);
`endif
    rst_n = 1'b1;
    chk("ready_at_release", a_ready, 0);
    @(posedge clk); #1;
    chk("ready_first_clk", a_ready, 1);

    // single block, back-to-back beats
    a_iready = 1'b1; a_lat = 1;
    exp_a(32'h0, 16'h000a, 16'h000b, 0, 1);
    do_req(32'h0, 0, acc0);
    chk("issue_latency_read", a_avm_read, 1);
    chk("issue_latency_addr", a_addr, 32'h0);
    drain_a("t1");
    chk("t1_ovalid_one_cycle", a_ovalid, 0);

    // pipelined requests, 3-cycle memory latency
    a_lat = 3;
    exp_a(32'h4, 16'h0001, 16'h0002, 1, 1);
    exp_a(32'h8, 16'h0003, 16'h0004, 2, 1);
    exp_a(32'hC, 16'h0005, 16'h0006, 3, 1);
    do_req(32'h0, 1, acc0);
    do_req(32'h0, 2, acc1);
    do_req(32'h0, 3, acc2);
    chk("spacing_1_2", 32'(acc1 - acc0), 3);
    chk("spacing_2_3", 32'(acc2 - acc1), 3);
    drain_a("t2");

    // backpressure: four credits then stall, one pop frees one slot
    a_iready = 1'b0; a_lat = 1;
    for (int i = 0; i < 5; i++)
      exp_a(32'h20 + 32'(4 * i), 16'(16'h0100 + i), 16'(16'h0200 + i), 32'(8 + i), 1);
    for (int i = 0; i < 4; i++) do_req(32'h0, 32'(8 + i), acc0);
    a_read = 1'b1; a_index = 32'd12;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_ready_low", a_ready, 0);
    chk("bp_ovalid_held", a_ovalid, 1);
    chk("bp_no_issue", a_avm_read, 0);
    a_iready = 1'b1;
    @(posedge clk); #1;
    a_iready = 1'b0;
    chk("bp_ready_after_pop", a_ready, 1);
    @(posedge clk); #1;
    a_read = 1'b0;
    chk("bp_fifth_issue", a_avm_read, 1);
    repeat (6) @(posedge clk);
    #1;
    a_iready = 1'b1;
    drain_a("t3");

    // waitrequest held for 5 cycles on beat 1
    a_lat = 2; a_wait_addr = 32'h2; a_wait_left = 5;
    exp_a(32'h0, 16'h1234, 16'h5678, 0, 1);
    do_req(32'h0, 0, acc0);
    drain_a("t4");
    chk("t4_wait_consumed", a_wait_left, 0);

    // address wraps modulo 2^32 between beats
    a_lat = 1;
    exp_a(32'hFFFF_FFFE, 16'haaaa, 16'h5555, 0, 1);
    do_req(32'hFFFF_FFFE, 0, acc0);
    drain_a("t5");

    // reset after the first of two beats; second beat arrives after release
    a_lat = 6;
    exp_a(32'h100, 16'hdead, 16'hbeef, 0, 0);
    cnt0 = a_rdv_cnt;
    do_req(32'h100, 0, acc0);
    n = 0;
    while (a_rdv_cnt == cnt0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_first_beat_seen", (a_rdv_cnt > cnt0), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", a_ready, 0);
    chk("t6_rst_ovalid", a_ovalid, 0);
    chk("t6_rst_data", a_data, 0);
    chk("t6_rst_read", a_avm_read, 0);
    chk("t6_rst_addr", a_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_lat = 1;
    exp_a(32'h1C, 16'h0007, 16'h0070, 7, 1);
    do_req(32'h0, 7, acc0);
    drain_a("t6");
    chk("t6_stale_consumed", a_pend.size(), 0);

    // wide bus, four beats
    b_iready = 1'b1;
    b_exp_addr_q.push_back(32'h1020); b_exp_addr_q.push_back(32'h1024);
    b_exp_addr_q.push_back(32'h1028); b_exp_addr_q.push_back(32'h102C);
    b_beat_q.push_back(32'h11111111); b_beat_q.push_back(32'h22222222);
    b_beat_q.push_back(32'h33333333); b_beat_q.push_back(32'h44444444);
    b_exp_out_q.push_back(128'h11111111_22222222_33333333_44444444);
    b_exp_tag_q.push_back(32'd2);
    do_req_b(32'h1000, 2);
    n = 0;
    while ((b_exp_out_q.size() != 0 || b_exp_addr_q.size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("b_drained", (b_exp_out_q.size() == 0 && b_exp_addr_q.size() == 0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("b_ovalid_idle", b_ovalid, 0);
    chk("a_beats_consumed", a_beat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
